// File: rtl/mac_kbd_pkg.sv
// rtl/mac_kbd_pkg.sv - shared types and constants for the Mac Plus keyboard host
// Protocol command/response bytes and the host FSM state encoding.
package mac_kbd_pkg;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      SEND,
      TURN,
      RECV
   } kbd_state_t;

   localparam logic [7:0] INQUIRY  = 8'h10;
   localparam logic [7:0] INSTANT  = 8'h14;
   localparam logic [7:0] MODEL    = 8'h16;
   localparam logic [7:0] TEST     = 8'h36;

   localparam logic [7:0] NULL_RSP = 8'h7B;
   localparam logic [7:0] TEST_ACK = 8'h7D;

   localparam int CNT_W = 21;

endpackage

// File: rtl/mac_kbd_host_if.sv
// rtl/mac_kbd_host_if.sv - command/response register-side bundle of the keyboard host
// master is the CPU/test side, slave is the keyboard host.
interface mac_kbd_host_if;

   logic [7:0] cmd;
   logic       cmd_strobe;
   logic       busy;
   logic [7:0] rsp;
   logic       rsp_strobe;
   logic       rsp_timeout;

   modport master (
      output cmd, cmd_strobe,
      input  busy, rsp, rsp_strobe, rsp_timeout
   );

   modport slave (
      input  cmd, cmd_strobe,
      output busy, rsp, rsp_strobe, rsp_timeout
   );

endinterface

// File: rtl/kbd_line_sync.sv
// rtl/kbd_line_sync.sv - 2-flop synchronizer with enable-qualified edge detect
// Edges are reported only on en ticks, comparing against the value seen on the previous tick.
module kbd_line_sync #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic _systemReset,
   input  logic en,
   input  logic line,
   output logic level,
   output logic rise,
   output logic fall
);

   logic meta_q, sync_q, prev_q;

   always_ff @(posedge clk or negedge _systemReset) begin
      if (!_systemReset) begin
         meta_q <= RESET_VAL;
         sync_q <= RESET_VAL;
         prev_q <= RESET_VAL;
      end else begin
         meta_q <= line;
         sync_q <= meta_q;
         if (en) begin
            prev_q <= sync_q;
         end
      end
   end

   assign level = sync_q;
   assign rise  = en & sync_q & ~prev_q;
   assign fall  = en & ~sync_q & prev_q;

endmodule

// File: rtl/mac_kbd_host.sv
// rtl/mac_kbd_host.sv - Mac-side host of the Mac Plus keyboard serial link
// Sends one command byte on the keyboard-owned clock, then receives the 8-bit reply.
module mac_kbd_host
   import mac_kbd_pkg::*;
#(
   parameter int BIT_TIMEOUT  = 4000,
   parameter int RESP_TIMEOUT = 2000000,
   parameter int SETUP_TICKS  = 16
) (
   input  logic           clk,
   input  logic           _systemReset,
   input  logic           clk8_en_p,
   mac_kbd_host_if.slave  host,
   input  logic           kbd_clk_i,
   input  logic           kbd_dat_i,
   output logic           kbd_dat_o
);

   localparam logic [CNT_W-1:0] BIT_LIM   = CNT_W'(BIT_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] RESP_LIM  = CNT_W'(RESP_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] SETUP_LIM = CNT_W'(SETUP_TICKS - 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;

   kbd_state_t       state, state_n;
   logic [7:0]       sr, sr_n, rsp_q, rsp_n;
   logic [2:0]       bitcnt, bitcnt_n;
   logic [CNT_W-1:0] cnt, cnt_n, limit;
   logic             dat_q, dat_n, rsp_stb_q, rsp_stb_n, tmo_q, tmo_n;
   logic             clk_level, clk_rise, clk_fall;
   logic             dat_level, dat_rise, dat_fall;
   logic             unused_edges;

   kbd_line_sync u_clk_sync (
      .clk          (clk),
      ._systemReset (_systemReset),
      .en           (clk8_en_p),
      .line         (kbd_clk_i),
      .level        (clk_level),
      .rise         (clk_rise),
      .fall         (clk_fall)
   );

   kbd_line_sync u_dat_sync (
      .clk          (clk),
      ._systemReset (_systemReset),
      .en           (clk8_en_p),
      .line         (kbd_dat_i),
      .level        (dat_level),
      .rise         (dat_rise),
      .fall         (dat_fall)
   );

   assign unused_edges = ^{clk_level, dat_rise, dat_fall};

   always_ff @(posedge clk or negedge _systemReset) begin
      if (!_systemReset) begin
         state     <= IDLE;
         sr        <= '0;
         rsp_q     <= '0;
         bitcnt    <= '0;
         cnt       <= '0;
         dat_q     <= 1'b1;
         rsp_stb_q <= 1'b0;
         tmo_q     <= 1'b0;
      end else if (clk8_en_p) begin
         state     <= state_n;
         sr        <= sr_n;
         rsp_q     <= rsp_n;
         bitcnt    <= bitcnt_n;
         cnt       <= cnt_n;
         dat_q     <= dat_n;
         rsp_stb_q <= rsp_stb_n;
         tmo_q     <= tmo_n;
      end
   end

   always_comb begin
      state_n   = state;
      sr_n      = sr;
      rsp_n     = rsp_q;
      bitcnt_n  = bitcnt;
      dat_n     = dat_q;
      rsp_stb_n = 1'b0;
      tmo_n     = 1'b0;
      limit     = (state == TURN) ? RESP_LIM : BIT_LIM;

      // Timeout is evaluated first so a coincident clock edge loses to it.
      if (state != IDLE && cnt >= limit) begin
         state_n = IDLE;
         dat_n   = 1'b1;
         tmo_n   = 1'b1;
      end else begin
         unique case (state)
            IDLE: begin
               dat_n = 1'b1;
               if (host.cmd_strobe) begin
                  sr_n    = host.cmd;
                  dat_n   = 1'b0;
                  state_n = REQ;
               end
            end
            REQ: begin
               if (cnt >= SETUP_LIM) begin
                  state_n  = SEND;
                  bitcnt_n = '0;
                  dat_n    = sr[7];
               end
            end
            SEND: begin
               if (clk_rise) begin
                  sr_n     = {sr[6:0], 1'b0};
                  bitcnt_n = bitcnt + 3'd1;
                  dat_n    = (bitcnt == 3'd7) ? 1'b0 : sr[6];
                  if (bitcnt == 3'd7) begin
                     state_n = TURN;
                  end
               end
            end
            TURN: begin
               // Low while dat_q is 0 means the release has not happened yet.
               if (!dat_q && cnt >= SETUP_LIM) begin
                  dat_n = 1'b1;
               end else if (dat_q && clk_fall) begin
                  state_n  = RECV;
                  bitcnt_n = '0;
               end
            end
            RECV: begin
               dat_n = 1'b1;
               if (clk_rise) begin
                  sr_n     = {sr[6:0], dat_level};
                  bitcnt_n = bitcnt + 3'd1;
                  if (bitcnt == 3'd7) begin
                     rsp_n     = {sr[6:0], dat_level};
                     rsp_stb_n = 1'b1;
                     state_n   = IDLE;
                  end
               end
            end
            default: begin
               state_n = IDLE;
               dat_n   = 1'b1;
            end
         endcase
      end

      if (state_n != state || state == IDLE || clk_rise || clk_fall) begin
         cnt_n = '0;
      end else if (cnt != CNT_MAX) begin
         cnt_n = cnt + 1'b1;
      end else begin
         cnt_n = cnt;
      end
   end

   assign host.busy        = (state != IDLE);
   assign host.rsp         = rsp_q;
   assign host.rsp_strobe  = rsp_stb_q;
   assign host.rsp_timeout = tmo_q;
   assign kbd_dat_o        = dat_q;

endmodule
